// File: rtl/uart_tx.sv
// 8-bit UART transmitter (8N1/8N2, LSB first) with a valid/ready byte input.
// uartTx is registered; busy/txReady are decoded from the state register only.
module uart_tx #(
  parameter int unsigned DELAY_FRAMES = 234,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       uartTx,
  output logic       busy
);

  localparam int unsigned CW = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(DELAY_FRAMES - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DELAY_FRAMES < 2) begin : g_bad_delay
      $error("uart_tx: DELAY_FRAMES must be 2 or more");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          cyc_end;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after the edge.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    cyc_end = (cyc_q == CYC_LAST);

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (txValid) begin
          state_d = START;
          cyc_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          shift_d = txData;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cyc_end) begin
          cyc_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (cyc_end) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          // Exit is decoded at count 7 rather than relying on the wrap to 0.
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cyc_end) begin
          cyc_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign uartTx  = tx_q;
  assign busy    = (state_q != IDLE);
  assign txReady = (state_q == IDLE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter, 8N1 or 8N2, LSB first. It is the transmit counterpart of the existing `uart` receive block.
- Upstream logic (button handlers, echo/loopback logic) hands it bytes over a valid/ready handshake. It serialises each byte onto `uartTx` at a bit period of `DELAY_FRAMES` clocks.
- Sits at the top level next to the receiver, driving the board's UART TX pin.

Parameters:
- `DELAY_FRAMES`, 234, clocks per bit (27 MHz / 115200). Legal range is 2 or more. Benches use 8.
- `STOP_BITS`, 1, number of stop bits. Legal values are 1 or 2; any other value is a synthesis error.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rstN`  input  1  reset, asynchronous and active-low.
- `txData`  input  8  byte to send. Sampled only in the accept cycle.
- `txValid`  input  1  upstream has a byte on `txData`.
- `txReady`  output  1  block can accept a byte this cycle.
- `uartTx`  output  1  serial line. Idle level is high.
- `busy`  output  1  a frame is in progress.

Behaviour:
- Reset (`rstN` = 0, asynchronous):
  - State goes to IDLE. `uartTx` = 1, `txReady` = 1, `busy` = 0.
  - Bit counter = 0, cycle counter = 0, shift register = 0.
  - Assertion mid-frame aborts the frame immediately. The line goes high at once, with no partial stop bit; the byte is discarded.
  - Release is synchronous to the next rising edge of `clk`.
- All outputs are registered, or decoded from state only. There is no combinational path from `txValid` or `txData` to any output.
- Accept:
  - A transfer occurs on a rising edge where `txValid` = 1 and `txReady` = 1.
  - `txData` is captured into the shift register on that edge.
  - Later changes to `txData` or `txValid` have no effect until the next accept.
- Handshake rules:
  - `txReady` = 1 only in IDLE.
  - `txValid` may rise at any time and may be withdrawn before acceptance without effect.
  - `txValid` held high while busy is simply waited on.
- States:
  - IDLE: `uartTx` = 1.
    - On accept, go to START, clear the cycle counter, and set `busy` = 1 on the same edge.
  - START: `uartTx` = 0 for exactly `DELAY_FRAMES` clocks, then go to DATA.
  - DATA: eight bits are driven LSB first, each for exactly `DELAY_FRAMES` clocks.
    - At each bit end, shift right and increment the bit counter (3 bits).
    - After bit 7, go to STOP. Bit-counter wrap is not relied on; the transition is decoded at count 7.
  - STOP: `uartTx` = 1 for `STOP_BITS` × `DELAY_FRAMES` clocks, then go to IDLE with `busy` = 0.
- Cycle counter:
  - Width is `$clog2(DELAY_FRAMES)`.
  - Counts 0 to `DELAY_FRAMES`−1, then wraps to 0 and advances the bit.
  - No off-by-one: every bit is exactly `DELAY_FRAMES` clocks wide as seen on `uartTx`.
- Latency:
  - `uartTx` falls on the same edge as the accept.
  - `uartTx` is low for the `DELAY_FRAMES` cycles following that edge.
- Frame length:
  - (1 + 8 + `STOP_BITS`) × `DELAY_FRAMES` clocks from the accept edge to IDLE re-entry.
  - IDLE lasts at least one cycle before the next accept.
  - With `txValid` held high, consecutive start bits are therefore exactly (9 + `STOP_BITS`) × `DELAY_FRAMES` + 1 clocks apart.
- `busy` = 1 from the accept edge until the edge entering IDLE. `txReady` = ~`busy` at all times.
- `txValid` during reset: ignored. The first accept is possible on the first edge after release.
- Glitch-free output: `uartTx` changes only at bit boundaries.

Test Plan:
- Reset check (`DELAY_FRAMES`=8): hold `rstN`=0 with `txValid`=1 → `uartTx`=1, `txReady`=1, `busy`=0. Release → accept on the first edge.
- Single byte 0x41, `DELAY_FRAMES`=8, `STOP_BITS`=1:
  - Line reads 0,1,0,0,0,0,0,1,0,1, each bit exactly 8 clocks.
  - `busy` is high for 80 clocks, then `txReady`=1.
- Back-to-back 0x55 then 0xAA with `txValid` held:
  - Second start-bit falling edge is exactly 81 clocks after the first.
  - Decoded bytes are 0x55 and 0xAA.
- Data stability: change `txData` from 0x0F to 0xF0 one cycle after accept → transmitted byte is 0x0F.
- `STOP_BITS`=2, byte 0xFF: stop level lasts 16 clocks, frame is 88 clocks, IDLE re-entered at 88.
- Mid-frame reset during data bit 3 of 0x00:
  - `uartTx` goes to 1 asynchronously, `busy`=0.
  - After release a new byte 0x81 is sent cleanly.
- Loopback: connect `uartTx` to the existing `uart` receiver (`DELAY_FRAMES`=8) and send 0x3C → receiver reports 0x3C.
